// File: rtl/blake3_pkg.sv
// Shared types, constants and the message permutation for the BLAKE3 datapath.
package blake3_pkg;

    localparam int BLK_WORD_W = 32;
    localparam int NUM_WORDS  = 16;
    localparam int NUM_G      = 8;

    typedef logic [BLK_WORD_W-1:0] word_t;
    // Packed so word j sits at bits [j*BLK_WORD_W +: BLK_WORD_W], matching the bus layout.
    typedef word_t [NUM_WORDS-1:0] msg_blk_t;

    // Applied between rounds: m'[j] = m[MSG_PERM[j]].
    localparam int MSG_PERM [NUM_WORDS] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic msg_blk_t msg_permute(input msg_blk_t m);
        msg_blk_t p;
        for (int j = 0; j < NUM_WORDS; j++) begin
            p[j] = m[MSG_PERM[j]];
        end
        return p;
    endfunction

endpackage

// File: rtl/blake3_msg_scheduler.sv
// Message-word scheduler: takes one 16-word block and streams the (X, Y)
// word pair for every G call of every round, permuting the block in place
// between rounds. The output pair is registered and held under back-pressure.
module blake3_msg_scheduler
    import blake3_pkg::*;
#(
    parameter int NUM_ROUNDS = 7,   // 1..8
    parameter int WORD_W     = 32   // must equal BLK_WORD_W
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Blk_Valid_I,
    output logic                   Blk_Ready_O,
    input  logic [16*WORD_W-1:0]   Blk_Msg_I,
    output logic                   Out_Valid_O,
    input  logic                   Out_Ready_I,
    output logic [WORD_W-1:0]      X_O,
    output logic [WORD_W-1:0]      Y_O,
    output logic [2:0]             Round_O,
    output logic [2:0]             Gidx_O,
    output logic                   Last_O
);

    localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);
    localparam logic [2:0] LAST_G     = 3'(NUM_G - 1);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;

    msg_blk_t            r_msg;
    logic [WORD_W-1:0]   r_x;
    logic [WORD_W-1:0]   r_y;
    logic [2:0]          r_round;
    logic [2:0]          r_gidx;
    logic                r_last;

    msg_blk_t            w_msg_nxt;
    logic [WORD_W-1:0]   w_x_nxt;
    logic [WORD_W-1:0]   w_y_nxt;
    logic [2:0]          w_round_nxt;
    logic [2:0]          w_gidx_nxt;
    logic                w_last_nxt;

    msg_blk_t            w_perm;
    logic [3:0]          w_x_idx;
    logic [3:0]          w_y_idx;

    // Next call within a round reads the adjacent even/odd word pair.
    assign w_x_idx = {r_gidx + 3'd1, 1'b0};
    assign w_y_idx = w_x_idx | 4'd1;
    assign w_perm  = msg_permute(r_msg);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-pair selection.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        w_state_nxt = r_state;
        w_msg_nxt   = r_msg;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_round_nxt = r_round;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;

        unique case (r_state)
            ST_IDLE: begin
                if (Blk_Valid_I) begin
                    w_msg_nxt   = Blk_Msg_I;
                    w_x_nxt     = Blk_Msg_I[0 +: WORD_W];
                    w_y_nxt     = Blk_Msg_I[WORD_W +: WORD_W];
                    w_round_nxt = 3'd0;
                    w_gidx_nxt  = 3'd0;
                    w_last_nxt  = 1'b0;   // G0 is never the final call
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Out_Ready_I) begin
                    if (r_last) begin
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else if (r_gidx == LAST_G) begin
                        w_msg_nxt   = w_perm;
                        w_x_nxt     = w_perm[0];
                        w_y_nxt     = w_perm[1];
                        w_round_nxt = r_round + 3'd1;
                        w_gidx_nxt  = 3'd0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_x_nxt     = r_msg[w_x_idx];
                        w_y_nxt     = r_msg[w_y_idx];
                        w_gidx_nxt  = r_gidx + 3'd1;
                        w_last_nxt  = (r_round == LAST_ROUND) && (r_gidx == LAST_G - 3'd1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Block storage and registered output pair.
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: the block store is reset too, so no word of an aborted block
        // can survive into the next one.
        if (!Rst_n) begin
            r_msg   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_round <= '0;
            r_gidx  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_msg   <= w_msg_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_round <= w_round_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign Blk_Ready_O = (r_state == ST_IDLE);
    assign Out_Valid_O = (r_state == ST_RUN);
    assign X_O         = r_x;
    assign Y_O         = r_y;
    assign Round_O     = r_round;
    assign Gidx_O      = r_gidx;
    assign Last_O      = r_last;

endmodule

// File: tb/tb_blake3_msg_scheduler.sv
// Randomised bench for blake3_msg_scheduler against a round-by-round
// reference model of the BLAKE3 message schedule.
module tb_blake3_msg_scheduler;

    localparam int NR    = 7;
    localparam int W     = 32;
    localparam int NPAIR = 8 * NR;
    localparam int PERM [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2:0]   rnd;
        logic [2:0]   g;
        logic         last;
    } pair_t;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              Blk_Valid_I = 1'b0;
    logic              Blk_Ready_O;
    logic [16*W-1:0]   Blk_Msg_I = '0;
    logic              Out_Valid_O;
    logic              Out_Ready_I = 1'b0;
    logic [W-1:0]      X_O;
    logic [W-1:0]      Y_O;
    logic [2:0]        Round_O;
    logic [2:0]        Gidx_O;
    logic              Last_O;

    int n_checks = 0;
    int n_fail   = 0;
    pair_t exp_q[$];

    always #5 Clk = ~Clk;

    blake3_msg_scheduler #(.NUM_ROUNDS(NR), .WORD_W(W)) u_dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Blk_Valid_I (Blk_Valid_I),
        .Blk_Ready_O (Blk_Ready_O),
        .Blk_Msg_I   (Blk_Msg_I),
        .Out_Valid_O (Out_Valid_O),
        .Out_Ready_I (Out_Ready_I),
        .X_O         (X_O),
        .Y_O         (Y_O),
        .Round_O     (Round_O),
        .Gidx_O      (Gidx_O),
        .Last_O      (Last_O)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pair_t observed();
        pair_t p;
        p.x = X_O; p.y = Y_O; p.rnd = Round_O; p.g = Gidx_O; p.last = Last_O;
        return p;
    endfunction

    function automatic logic [16*W-1:0] rand_blk();
        logic [16*W-1:0] b;
        for (int j = 0; j < 16; j++) b[j*W +: W] = $urandom;
        return b;
    endfunction

    function automatic logic [16*W-1:0] ramp_blk(input int base);
        logic [16*W-1:0] b;
        for (int j = 0; j < 16; j++) b[j*W +: W] = W'(base + j);
        return b;
    endfunction

    // Reference: for each round emit (m[2g], m[2g+1]) for g=0..7, then permute.
    task automatic build_expected(input logic [16*W-1:0] blk);
        logic [W-1:0] m [16];
        logic [W-1:0] t [16];
        pair_t p;
        exp_q.delete();
        for (int j = 0; j < 16; j++) m[j] = blk[j*W +: W];
        for (int r = 0; r < NR; r++) begin
            for (int g = 0; g < 8; g++) begin
                p.x = m[2*g]; p.y = m[2*g+1];
                p.rnd = 3'(r); p.g = 3'(g);
                p.last = (r == NR-1) && (g == 7);
                exp_q.push_back(p);
            end
            for (int j = 0; j < 16; j++) t[j] = m[PERM[j]];
            m = t;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk_ready"}, Blk_Ready_O, 1);
        check({tag, "_out_valid"}, Out_Valid_O, 0);
        check({tag, "_pair"}, observed(), '0);
    endtask

    // Starts at a negedge with the scheduler idle; ends at the negedge after the
    // last handshake (or after an abort reset has been released).
    task automatic run_block(input logic [16*W-1:0] blk, input bit rand_ready,
                             input bit hold_next, input logic [16*W-1:0] next_blk,
                             input int abort_k, input bit spot);
        int  k = 0;
        int  cycles = 0;
        bit  rdy;
        build_expected(blk);
        Blk_Valid_I = 1'b1;
        Blk_Msg_I   = blk;
        check("blk_ready_idle", Blk_Ready_O, 1);
        check("out_valid_idle", Out_Valid_O, 0);
        @(negedge Clk);
        Blk_Valid_I = hold_next;
        Blk_Msg_I   = hold_next ? next_blk : rand_blk();
        while (k < NPAIR) begin
            if (cycles > 4*NPAIR + 100) begin
                check("cycle_budget", cycles, 0);
                break;
            end
            check("out_valid_run", Out_Valid_O, 1);
            check("blk_ready_run", Blk_Ready_O, 0);
            check($sformatf("pair%0d", k), observed(), exp_q[k]);
            if (spot) begin
                case (k)
                    0:  check("r0g0_xy", {X_O, Y_O}, {32'd0,  32'd1});
                    7:  check("r0g7_xy", {X_O, Y_O}, {32'd14, 32'd15});
                    8:  check("r1g0_xy", {X_O, Y_O}, {32'd2,  32'd6});
                    15: check("r1g7_xy", {X_O, Y_O}, {32'd15, 32'd8});
                    16: check("r2g0_xy", {X_O, Y_O}, {32'd3,  32'd4});
                    default: ;
                endcase
            end
            if (k == abort_k) begin
                Rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                Out_Ready_I = 1'b0;
                Blk_Valid_I = 1'b0;
                @(negedge Clk);
                check_reset_outputs("abort_held");
                Rst_n = 1'b1;
                return;
            end
            rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            Out_Ready_I = rdy;
            if (!hold_next && rand_ready) begin
                Blk_Valid_I = 1'($urandom_range(0, 1));
                Blk_Msg_I   = rand_blk();
            end
            @(negedge Clk);
            cycles++;
            if (rdy) k++;
        end
        Out_Ready_I = 1'($urandom_range(0, 1));
        if (!hold_next) Blk_Valid_I = 1'b0;
        check("handshakes", k, NPAIR);
        check("done_out_valid", Out_Valid_O, 0);
        check("done_blk_ready", Blk_Ready_O, 1);
        check("done_last", Last_O, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*W-1:0] blk_a;
        logic [16*W-1:0] blk_b;

        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Out_Ready_I = 1'b1;
        @(negedge Clk);
        check_reset_outputs("reset_ready_ignored");
        Rst_n = 1'b1;
        @(negedge Clk);

        // Directed ramp block at full rate.
        run_block(ramp_blk(0), 1'b0, 1'b0, '0, -1, 1'b1);
        @(negedge Clk);

        // Same block with random back-pressure and ignored block pulses.
        run_block(ramp_blk(0), 1'b1, 1'b0, '0, -1, 1'b0);
        @(negedge Clk);

        // Random blocks under random back-pressure.
        for (int i = 0; i < 3; i++) begin
            run_block(rand_blk(), 1'b1, 1'b0, '0, -1, 1'b0);
            repeat ($urandom_range(1, 3)) @(negedge Clk);
        end

        // Abort at round 3 G4, then a fresh block.
        run_block(rand_blk(), 1'b0, 1'b0, '0, 3*8 + 4, 1'b0);
        run_block(ramp_blk(16), 1'b1, 1'b0, '0, -1, 1'b0);
        @(negedge Clk);

        // Back-to-back blocks with the block valid held high throughout.
        blk_a = rand_blk();
        blk_b = rand_blk();
        run_block(blk_a, 1'b0, 1'b1, blk_b, -1, 1'b0);
        run_block(blk_b, 1'b1, 1'b0, '0, -1, 1'b0);
        @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blake3_msg_scheduler.md
Name: blake3_msg_scheduler

Overview:
- Upstream feeder for the pipelined G_function mixing stage.
- Accepts one 16-word (512-bit) message block and emits the per-call message-word pairs (X, Y) for every G invocation of every round.
- Applies the BLAKE3 message permutation between rounds.
- Output is a registered valid/ready stream consumed by the round controller that drives G_function X_I/Y_I.

Parameters:
- NUM_ROUNDS, 7, number of rounds emitted per block (legal range 1..8).
- WORD_W, 32, message word width in bits.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Blk_Valid_I  input  1  message block present on Blk_Msg_I.
- Blk_Ready_O  output  1  scheduler can accept a block.
- Blk_Msg_I  input  16*WORD_W  message words; word j at bits [j*WORD_W +: WORD_W].
- Out_Valid_O  output  1  X_O/Y_O hold a valid pair.
- Out_Ready_I  input  1  consumer takes the pair this cycle.
- X_O  output  WORD_W  first message word for the current G call.
- Y_O  output  WORD_W  second message word for the current G call.
- Round_O  output  3  round index of the current pair, 0..NUM_ROUNDS-1.
- Gidx_O  output  3  G call index within the round, 0..7.
- Last_O  output  1  high with the final pair of the block (round NUM_ROUNDS-1, G7).

Behaviour:
- Clock and reset: one clock domain (Clk). Rst_n is asynchronous and active-low.
- Reset values while Rst_n=0: state IDLE; Blk_Ready_O=1; Out_Valid_O=0; X_O, Y_O, Round_O, Gidx_O, Last_O all 0; internal 16-word register all 0.
- States: IDLE and RUN.
- IDLE:
  - Blk_Ready_O=1 and Out_Valid_O=0.
  - On Blk_Valid_I=1 at a rising edge: capture Blk_Msg_I into m[0..15].
  - On the same edge, register X_O=Blk_Msg_I word 0, Y_O=word 1, Round_O=0, Gidx_O=0, Last_O=(NUM_ROUNDS==1 ? 0 : 0). The first pair is never last, because G7 is always the last call of a round.
  - On the same edge, go to RUN.
- Latency: first pair is visible (Out_Valid_O=1) in the cycle after the block handshake.
- RUN:
  - Blk_Ready_O=0; Blk_Valid_I is ignored.
  - Out_Valid_O=1 continuously; X_O, Y_O, Round_O, Gidx_O and Last_O stay stable while Out_Ready_I=0.
  - Handshake with Gidx_O=g<7: next pair is X_O=m[2g+2], Y_O=m[2g+3], Gidx_O=g+1.
  - Handshake with Gidx_O=7 and Round_O=r<NUM_ROUNDS-1:
    - permute in place, m'[j]=m[MSG_PERM[j]];
    - register X_O=m'[0], Y_O=m'[1], Round_O=r+1, Gidx_O=0, all on the same edge.
  - Handshake with Last_O=1: go to IDLE, Out_Valid_O=0, Blk_Ready_O=1 on the next cycle.
- Last_O=1 exactly when Round_O=NUM_ROUNDS-1 and Gidx_O=7 are presented.
- MSG_PERM = {2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8}.
- Throughput: 8*NUM_ROUNDS pairs per block, one per cycle when Out_Ready_I is held high, then one IDLE cycle before the next block can be accepted.
- No arithmetic: pure word selection; widths are preserved and no truncation occurs.
- Reset mid-RUN:
  - abort immediately (asynchronously) to the reset values;
  - no residual pairs are emitted after reset release;
  - the next block is accepted normally.
- Out_Ready_I while Out_Valid_O=0 has no effect.

Decomposition:
- Shared package blake3_pkg holds:
  - typedef word_t (WORD_W bits);
  - typedef msg_blk_t (16 x word_t);
  - localparam MSG_PERM array;
  - localparam NUM_G=8;
  - a function msg_permute(msg_blk_t) returning msg_blk_t.
- No sub-module is needed; the permutation is the package function and the FSM plus datapath is a single module.

Test Plan:
- Reset then load m[j]=j, Out_Ready_I=1 → cycle after load: X_O=0, Y_O=1, Round_O=0, Gidx_O=0; round 0 G7 gives X_O=14, Y_O=15.
- Same block, round 1 → G0 X_O=2, Y_O=6; G7 X_O=15, Y_O=8. Round 2 G0 → X_O=3, Y_O=4.
- Full run with NUM_ROUNDS=7 → exactly 56 handshakes, Last_O only on the 56th (Round_O=6, Gidx_O=7), Blk_Ready_O=1 one cycle later.
- Out_Ready_I toggled pseudo-randomly → pair sequence identical to the full-rate run, outputs stable during stalls, and Blk_Valid_I pulses during RUN are ignored.
- Assert Rst_n=0 at round 3 G4 → outputs zero immediately; after release, load m[j]=16+j → first pair X_O=16, Y_O=17.
- Two back-to-back blocks with Blk_Valid_I held high → second block accepted in the IDLE cycle after Last_O; its first pair follows one cycle later.
